// File: rtl/hazard_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_pkg
// Shared types and constants for the hazard scoreboard slice:
//   NUM_REGS       - number of architectural integer registers (32)
//   reg_idx_t      - register index type (5 bits)
//   muldiv_state_e - mul/div slot state (MD_IDLE / MD_BUSY)
//   reg_onehot()   - one-hot register mask with x0 always excluded
// -----------------------------------------------------------------------------
package hazard_scoreboard_pkg;

  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = $clog2(NUM_REGS);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } muldiv_state_e;

  // x0 is hard-wired zero, so it never appears in a scoreboard mask.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_idx_t idx);
    logic [NUM_REGS-1:0] mask;
    mask      = '0;
    mask[idx] = 1'b1;
    mask[0]   = 1'b0;
    return mask;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_if
// Bundles the ID-stage request, writeback-event and stall/status signals that
// pass between the decode stage and the hazard scoreboard.
//   master : ID stage / pipeline control (drives requests, reads stall)
//   slave  : hazard_scoreboard
// Signals:
//   rs1_id, rs2_id, rs1_used_id, rs2_used_id - ID source operands
//   rd_id, reg_we_id, is_load_id, is_muldiv_id - ID destination and op class
//   issue_id  - ID instruction requests to advance
//   load_done - load data written back this cycle
//   flush     - pipeline redirect, discard in-flight tracking
//   stall_id  - hold ID/IF this cycle
//   muldiv_wb_valid, muldiv_wb_rd - mul/div writeback pulse and destination
//   pending   - per-register busy bits (bit 0 always 0)
// -----------------------------------------------------------------------------
interface hazard_scoreboard_if;
  import hazard_scoreboard_pkg::*;

  reg_idx_t              rs1_id;
  reg_idx_t              rs2_id;
  logic                  rs1_used_id;
  logic                  rs2_used_id;
  reg_idx_t              rd_id;
  logic                  reg_we_id;
  logic                  is_load_id;
  logic                  is_muldiv_id;
  logic                  issue_id;
  logic                  load_done;
  logic                  flush;
  logic                  stall_id;
  logic                  muldiv_wb_valid;
  reg_idx_t              muldiv_wb_rd;
  logic [NUM_REGS-1:0]   pending;

  modport master (
    output rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_id, reg_we_id,
           is_load_id, is_muldiv_id, issue_id, load_done, flush,
    input  stall_id, muldiv_wb_valid, muldiv_wb_rd, pending
  );

  modport slave (
    input  rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_id, reg_we_id,
           is_load_id, is_muldiv_id, issue_id, load_done, flush,
    output stall_id, muldiv_wb_valid, muldiv_wb_rd, pending
  );

endinterface

// File: rtl/hazard_scoreboard_muldiv_tracker.sv
// -----------------------------------------------------------------------------
// muldiv_tracker
// Single-entry mul/div slot: tracks one in-flight multi-cycle op, counts down
// its latency and emits a one-cycle writeback pulse carrying its destination.
// Parameters:
//   MULDIV_LAT - cycles from accept to writeback pulse (2..15)
// Ports:
//   clk, reset_n - clock, async active-low reset
//   flush        - drop the in-flight op without a writeback pulse
//   accept       - a mul/div is accepted this cycle (never while busy)
//   rd_in        - destination of the accepted op
//   busy         - slot cannot take a new op this cycle
//   wb_valid     - writeback pulse (registered)
//   wb_rd        - destination of the op writing back
// -----------------------------------------------------------------------------
module muldiv_tracker
  import hazard_scoreboard_pkg::*;
#(
  parameter int MULDIV_LAT = 4
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     flush,
  input  logic     accept,
  input  reg_idx_t rd_in,
  output logic     busy,
  output logic     wb_valid,
  output reg_idx_t wb_rd
);

  localparam int              CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MULDIV_LAT - 1);

  muldiv_state_e    state;
  logic [CNT_W-1:0] count;
  logic             wb_valid_q;
  reg_idx_t         rd_q;

  // The completion cycle (count==0) frees the slot so a new op can issue
  // back-to-back with the writeback.
  assign busy     = (state == MD_BUSY) && (count != '0);
  assign wb_valid = wb_valid_q;
  assign wb_rd    = rd_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= MD_IDLE;
      count      <= '0;
      wb_valid_q <= 1'b0;
      rd_q       <= '0;
    end else if (flush) begin
      state      <= MD_IDLE;
      count      <= '0;
      wb_valid_q <= 1'b0;
      rd_q       <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          wb_valid_q <= 1'b0;
          if (accept) begin
            state <= MD_BUSY;
            count <= CNT_INIT;
            rd_q  <= rd_in;
          end
        end
        MD_BUSY: begin
          if (count == '0) begin
            // Writeback happening now; either chain a new op or go idle.
            wb_valid_q <= 1'b0;
            if (accept) begin
              count <= CNT_INIT;
              rd_q  <= rd_in;
            end else begin
              state <= MD_IDLE;
            end
          end else begin
            count      <= count - 1'b1;
            wb_valid_q <= (count == CNT_W'(1));
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Register scoreboard for an in-order pipeline. Tracks destinations of an
// in-flight load (one slot) and, optionally, an in-flight mul/div (one slot),
// and stalls the ID stage on RAW hazards and structural slot conflicts.
// Parameters:
//   MULDIV_LAT - mul/div latency in cycles (2..15)
// Ports:
//   clk     - clock
//   reset_n - asynchronous active-low reset
//   bus     - hazard_scoreboard_if.slave (ID requests, stall, status)
// Configuration:
//   HAZARD_SCOREBOARD_MULDIV_EN - when defined, mul/div tracking is built;
//   otherwise is_muldiv_id is ignored and the writeback outputs are tied to 0.
// -----------------------------------------------------------------------------
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int MULDIV_LAT = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  hazard_scoreboard_if.slave  bus
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic                load_valid_q;
  reg_idx_t            load_rd_q;

  logic                data_hazard;
  logic                load_block;
  logic                md_block;
  logic                stall;
  logic                accept;
  logic                load_accept;
  logic                md_accept;
  logic                md_wb_valid;
  reg_idx_t            md_wb_rd;

  // RAW check against the registered scoreboard; bits retire the cycle after
  // their writeback, when forwarding already supplies the value.
  assign data_hazard = (bus.rs1_used_id && pending_q[bus.rs1_id]) ||
                       (bus.rs2_used_id && pending_q[bus.rs2_id]);

  // A load may replace the slot occupant in the cycle that occupant completes.
  assign load_block  = bus.is_load_id && load_valid_q && !bus.load_done;

  assign stall       = data_hazard || load_block || md_block;

  // Flush wins over a same-cycle issue.
  assign accept      = bus.issue_id && !stall && !bus.flush;
  assign load_accept = accept && bus.is_load_id;

`ifdef HAZARD_SCOREBOARD_MULDIV_EN
  logic md_busy;

  assign md_accept = accept && bus.is_muldiv_id;
  assign md_block  = bus.is_muldiv_id && md_busy;

  muldiv_tracker #(
    .MULDIV_LAT (MULDIV_LAT)
  ) u_muldiv_tracker (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (bus.flush),
    .accept   (md_accept),
    .rd_in    (bus.rd_id),
    .busy     (md_busy),
    .wb_valid (md_wb_valid),
    .wb_rd    (md_wb_rd)
  );
`else
  logic unused_md;

  assign md_accept   = 1'b0;
  assign md_block    = 1'b0;
  assign md_wb_valid = 1'b0;
  assign md_wb_rd    = '0;
  assign unused_md   = ^{bus.is_muldiv_id, 4'(MULDIV_LAT)};
`endif

  // Clears are applied before sets so a completing and a newly issued op
  // with the same destination leave the bit set.
  always_comb begin
    // NOTE: default first so every path assigns pending_d -- no latch.
    pending_d = pending_q;
    if (bus.load_done && load_valid_q) pending_d &= ~reg_onehot(load_rd_q);
    if (md_wb_valid)                   pending_d &= ~reg_onehot(md_wb_rd);
    if (load_accept && bus.reg_we_id)  pending_d |=  reg_onehot(bus.rd_id);
    if (md_accept)                     pending_d |=  reg_onehot(bus.rd_id);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: non-blocking assignments for all sequential state.
      pending_q    <= '0;
      load_valid_q <= 1'b0;
      load_rd_q    <= '0;
    end else if (bus.flush) begin
      pending_q    <= '0;
      load_valid_q <= 1'b0;
      load_rd_q    <= '0;
    end else begin
      pending_q <= pending_d;
      if (load_accept) begin
        // A non-writing load still occupies the slot; x0 marks "no bit".
        load_valid_q <= 1'b1;
        load_rd_q    <= bus.reg_we_id ? bus.rd_id : '0;
      end else if (bus.load_done) begin
        load_valid_q <= 1'b0;
      end
    end
  end

  assign bus.stall_id        = stall;
  assign bus.pending         = pending_q;
  assign bus.muldiv_wb_valid = md_wb_valid;
  assign bus.muldiv_wb_rd    = md_wb_rd;

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter: MULDIV_LAT, default 4, cycles from mul/div issue to writeback pulse; legal range 2..15.
REQ-002 Port: clk  in  1  single clock for all state.
REQ-003 Port: reset_n  in  1  reset, asynchronous assertion, active-low.
REQ-004 Ports: rs1_id, rs2_id  in  5 each  ID-stage source register numbers.
REQ-005 Ports: rs1_used_id, rs2_used_id  in  1 each  ID instruction actually reads that source.
REQ-006 Port: rd_id  in  5  ID-stage destination register number.
REQ-007 Ports: reg_we_id, is_load_id, is_muldiv_id  in  1 each  ID instruction writes rd; is a load; is a mul/div.
REQ-008 Port: issue_id  in  1  ID instruction requests to advance this cycle.
REQ-009 Port: load_done  in  1  load data written back this cycle.
REQ-010 Port: flush  in  1  pipeline redirect; discard all tracked in-flight ops.
REQ-011 Port: stall_id  out  1  hold ID and IF this cycle.
REQ-012 Ports: muldiv_wb_valid  out  1, muldiv_wb_rd  out  5  mul/div result writeback pulse and its destination.
REQ-013 Port: pending  out  32  scoreboard bit per register; bit 0 is always 0.

Function
REQ-014 Issue is accepted only when issue_id=1 and stall_id=0.
REQ-015 stall_id is combinational, same cycle: 1 if (rs1_used_id and pending[rs1_id]) or (rs2_used_id and pending[rs2_id]).
REQ-016 stall_id is also 1 on a structural hazard: is_load_id with the load slot occupied and load_done=0, or is_muldiv_id with the mul/div slot busy.
REQ-017 Accepted load with reg_we_id=1, rd_id!=0: sets pending[rd_id], load slot valid, records rd_id.
REQ-018 load_done with load slot valid: clears pending[slot rd] and the slot next cycle; load_done with empty slot is ignored.
REQ-019 load_done and a new accepted load in the same cycle: old rd cleared, new rd set; if the rds are equal, the bit stays set.
REQ-020 Accepted load with rd_id=0 or reg_we_id=0 occupies the slot without setting any pending bit.
REQ-021 Pending bits clear before the consumer in ID samples them; forwarding then supplies the value, so there is no extra bubble after load_done.
REQ-022 Mul/div slot states: IDLE, BUSY.
- IDLE->BUSY on accepted mul/div: counter := MULDIV_LAT-1; sets pending[rd_id] if rd_id!=0.
- BUSY: counter decrements each cycle.
- At counter=0: muldiv_wb_valid=1 for exactly one cycle with the recorded rd; pending bit cleared; state returns to IDLE.
REQ-023 A mul/div accepted in the same cycle as a completion is allowed: that cycle is not BUSY-blocked, and completion and new issue both take effect.
REQ-024 flush: all pending bits, the load slot and the mul/div slot clear next cycle; no muldiv_wb_valid pulses for the flushed op; a later load_done is ignored.
REQ-025 flush takes priority over an issue in the same cycle; that issue is discarded.

Reset
REQ-026 On reset_n=0: pending=0, both slots empty, state IDLE, counter=0, muldiv_wb_valid=0, muldiv_wb_rd=0.
REQ-027 Reset takes effect mid-operation without any writeback pulse.
REQ-028 stall_id is 0 throughout reset.

Configuration
REQ-029 Macro HAZARD_SCOREBOARD_MULDIV_EN:
- Defined: mul/div tracking as in REQ-022..023.
- Undefined: is_muldiv_id ignored; no mul/div slot or counter; muldiv_wb_valid=0 and muldiv_wb_rd=0 constant; MULDIV_LAT unused.

Structure
REQ-030 Shared core package holds the register-index type (5-bit), the NUM_REGS=32 constant and the mul/div state enum.
REQ-031 One sub-module, muldiv_tracker: the mul/div slot, counter and writeback pulse, instantiated only under the macro.

Verification
REQ-032 Load to x5, then an ID instruction reading rs1=x5 -> stall_id=1 until load_done; pending[5] drops the next cycle; stall_id=0 that cycle.
REQ-033 Mul/div to x7 with MULDIV_LAT=4 -> muldiv_wb_valid is a single pulse with rd=7 exactly 4 cycles after accept; a dependent read stalls 4 cycles.
REQ-034 Back-to-back loads to x3 then x4 -> second load stalls until load_done; with load_done in the same cycle there is no stall, pending[3]=0 and pending[4]=1.
REQ-035 Load to x0 then a read of rs1=x0 -> pending stays 0 and there is no stall.
REQ-036 flush while mul/div to x9 is BUSY -> pending=0 next cycle and there is never a muldiv_wb_valid pulse; with the macro undefined, is_muldiv_id=1 causes no stall.
